// File: rtl/block_deserialiser_pkg.sv
// -----------------------------------------------------------------------------
// block_deserialiser_pkg
//   Shared types and constants for the word-serial to ChaCha20 block path.
//   word_t        : one 32-bit matrix element / serial word
//   MATRIX_ROWS   : rows of the 4x4 state matrix
//   MATRIX_COLS   : columns of the 4x4 state matrix
//   BLOCK_WORDS   : words per block (ROWS*COLS)
//   bank_state_e  : life cycle of one storage bank of the double buffer
// -----------------------------------------------------------------------------
package block_deserialiser_pkg;

   typedef logic [31:0] word_t;

   localparam int MATRIX_ROWS = 4;
   localparam int MATRIX_COLS = 4;
   localparam int BLOCK_WORDS = MATRIX_ROWS * MATRIX_COLS;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_e;

endpackage : block_deserialiser_pkg

// File: rtl/block_deserialiser_if.sv
// -----------------------------------------------------------------------------
// block_deserialiser_if
//   Bundles the serial input handshake, the abort strobe, the block output
//   handshake and the status outputs of the block deserialiser.
//   master : word source / block consumer (drives in_word, in_valid, abort,
//            out_ready)
//   slave  : the deserialiser (drives in_ready, out_matrix, out_valid,
//            fill_level, blocks_out)
// -----------------------------------------------------------------------------
interface block_deserialiser_if
   import block_deserialiser_pkg::*;
#(
   parameter int WORD_W = $bits(word_t),
   parameter int ROWS   = MATRIX_ROWS,
   parameter int COLS   = MATRIX_COLS,
   parameter int CNT_W  = 32
);

   logic [WORD_W-1:0]                      in_word;
   logic                                   in_valid;
   logic                                   in_ready;
   logic                                   abort;
   logic [ROWS-1:0][COLS-1:0][WORD_W-1:0]  out_matrix;
   logic                                   out_valid;
   logic                                   out_ready;
   logic [4:0]                             fill_level;
   logic [CNT_W-1:0]                       blocks_out;

   modport master (
      output in_word, in_valid, abort, out_ready,
      input  in_ready, out_matrix, out_valid, fill_level, blocks_out
   );

   modport slave (
      input  in_word, in_valid, abort, out_ready,
      output in_ready, out_matrix, out_valid, fill_level, blocks_out
   );

endinterface : block_deserialiser_if

// File: rtl/block_deserialiser_bank.sv
// -----------------------------------------------------------------------------
// deser_bank
//   One 16-word storage bank of the ping-pong buffer, with its own
//   EMPTY/FILLING/FULL state and write index.
//   clk, rst    : clock, asynchronous active-low reset
//   i_wr_en     : store i_wr_word at the current index (word accepted)
//   i_wr_word   : incoming word
//   i_abort     : discard a partial fill (ignored once FULL)
//   i_drain     : consumer took this bank's block
//   o_words     : stored block, row-major
//   o_idx       : number of words written into the current fill
//   o_full      : bank holds a complete block
// -----------------------------------------------------------------------------
module deser_bank
   import block_deserialiser_pkg::*;
#(
   parameter int WORD_W = $bits(word_t),
   parameter int ROWS   = MATRIX_ROWS,
   parameter int COLS   = MATRIX_COLS,
   parameter int IDX_W  = $clog2(ROWS * COLS)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  i_wr_en,
   input  logic [WORD_W-1:0]                     i_wr_word,
   input  logic                                  i_abort,
   input  logic                                  i_drain,
   output logic [ROWS-1:0][COLS-1:0][WORD_W-1:0] o_words,
   output logic [IDX_W-1:0]                      o_idx,
   output logic                                  o_full
);

   localparam int NWORDS = ROWS * COLS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   bank_state_e       r_state;
   bank_state_e       w_state_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic [WORD_W-1:0] r_mem [NWORDS];
   logic              w_wr;
   logic              w_clear;

   // Abort only touches a bank that is not holding a finished block.
   assign w_clear = i_abort && (r_state != BANK_FULL);
   assign w_wr    = i_wr_en && !w_clear;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= BANK_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         BANK_EMPTY: begin
            if (w_wr) w_state_nxt = BANK_FILLING;
         end
         BANK_FILLING: begin
            if (w_clear)                        w_state_nxt = BANK_EMPTY;
            else if (w_wr && r_idx == LAST_IDX) w_state_nxt = BANK_FULL;
         end
         BANK_FULL: begin
            if (i_drain) w_state_nxt = BANK_EMPTY;
         end
         default: w_state_nxt = BANK_EMPTY;
      endcase
   end

   // Write index: wraps to 0 after the last word so the bank is ready to refill.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx <= '0;
      end else if (w_clear) begin
         r_idx <= '0;
      end else if (w_wr) begin
         r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
   end

   // Storage is cleared on reset so the output matrix reads zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NWORDS; i++) r_mem[i] <= '0;
      end else if (w_wr) begin
         r_mem[r_idx] <= i_wr_word;
      end
   end

   // Outputs
   always_comb begin
      o_full = (r_state == BANK_FULL);
      o_idx  = r_idx;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            o_words[r][c] = r_mem[r * COLS + c];
         end
      end
   end

endmodule : deser_bank

// File: rtl/block_deserialiser.sv
// -----------------------------------------------------------------------------
// block_deserialiser
//   Reassembles a stream of 32-bit words into 4x4 ChaCha20 state matrices
//   using two deser_bank instances as a ping-pong buffer: one bank fills
//   while the other waits for the consumer.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : block_deserialiser_if.slave
//          in_word/in_valid/in_ready : serial word handshake
//          abort                     : drop the partially filled block
//          out_matrix/out_valid/out_ready : block handshake
//          fill_level                : words in the filling bank
//          blocks_out                : blocks handed off (wraps)
// -----------------------------------------------------------------------------
module block_deserialiser
   import block_deserialiser_pkg::*;
#(
   parameter int WORD_W = $bits(word_t),
   parameter int ROWS   = MATRIX_ROWS,
   parameter int COLS   = MATRIX_COLS,
   parameter int CNT_W  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   block_deserialiser_if.slave  bus
);

   localparam int IDX_W = $clog2(ROWS * COLS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS * COLS - 1);

   logic                                  r_fill_ptr;
   logic                                  r_rd_ptr;
   logic [CNT_W-1:0]                      r_blocks_out;

   logic                                  w_bank_full  [2];
   logic [IDX_W-1:0]                      w_bank_idx   [2];
   logic [ROWS-1:0][COLS-1:0][WORD_W-1:0] w_bank_words [2];

   logic                                  w_in_ready;
   logic                                  w_accept;
   logic                                  w_last;
   logic                                  w_out_valid;
   logic                                  w_drain;

   // in_ready is deliberately not gated by abort; abort wins inside w_accept.
   assign w_in_ready  = !w_bank_full[r_fill_ptr];
   assign w_accept    = bus.in_valid && w_in_ready && !bus.abort;
   assign w_last      = w_accept && (w_bank_idx[r_fill_ptr] == LAST_IDX);
   assign w_out_valid = w_bank_full[r_rd_ptr];
   assign w_drain     = w_out_valid && bus.out_ready;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      deser_bank #(
         .WORD_W (WORD_W),
         .ROWS   (ROWS),
         .COLS   (COLS),
         .IDX_W  (IDX_W)
      ) u_bank (
         .clk       (clk),
         .rst       (rst),
         .i_wr_en   (w_accept  && (r_fill_ptr == 1'(b))),
         .i_wr_word (bus.in_word),
         .i_abort   (bus.abort && (r_fill_ptr == 1'(b))),
         .i_drain   (w_drain   && (r_rd_ptr   == 1'(b))),
         .o_words   (w_bank_words[b]),
         .o_idx     (w_bank_idx[b]),
         .o_full    (w_bank_full[b])
      );
   end

   // Fill and read pointers move independently, so completion of one bank
   // and hand-off of the other can happen in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fill_ptr   <= 1'b0;
         r_rd_ptr     <= 1'b0;
         r_blocks_out <= '0;
      end else begin
         if (w_last)  r_fill_ptr <= !r_fill_ptr;
         if (w_drain) begin
            r_rd_ptr     <= !r_rd_ptr;
            r_blocks_out <= r_blocks_out + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_matrix = w_bank_words[r_rd_ptr];
   assign bus.fill_level = 5'(w_bank_idx[r_fill_ptr]);
   assign bus.blocks_out = r_blocks_out;

endmodule : block_deserialiser

// File: tb/tb_block_deserialiser.sv
// -----------------------------------------------------------------------------
// tb_block_deserialiser
//   Scoreboard bench: completed blocks are modelled as words are accepted and
//   compared against out_matrix at each output handshake.
// -----------------------------------------------------------------------------
module tb_block_deserialiser;
   import block_deserialiser_pkg::*;

   typedef logic [511:0] mat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   block_deserialiser_if bif ();

   block_deserialiser dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   mat_t        exp_q [$];
   mat_t        cur_blk  = '0;
   int          cur_idx  = 0;
   logic [31:0] exp_blocks = '0;

   task automatic chk(input string tag, input mat_t obs, input mat_t exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_accept(input word_t w);
      cur_blk[cur_idx*32 +: 32] = w;
      cur_idx++;
      if (cur_idx == BLOCK_WORDS) begin
         exp_q.push_back(cur_blk);
         cur_blk = '0;
         cur_idx = 0;
      end
   endtask

   task automatic model_drop_partial();
      cur_blk = '0;
      cur_idx = 0;
   endtask

   task automatic model_reset();
      model_drop_partial();
      exp_q.delete();
      exp_blocks = '0;
   endtask

   // Called 1 time unit after a rising edge; returns at the same phase.
   task automatic send_word(input word_t w, output int waits);
      waits = 0;
      bif.in_word  = w;
      bif.in_valid = 1'b1;
      @(negedge clk);
      while (!bif.in_ready && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (!bif.in_ready) begin
         chk("in_ready_timeout", mat_t'(bif.in_ready), 1);
         @(posedge clk); #1;
      end else begin
         @(posedge clk); #1;
         model_accept(w);
      end
      bif.in_valid = 1'b0;
   endtask

   task automatic send_words(input word_t base, input int n);
      int waits;
      for (int i = 0; i < n; i++) send_word(base + word_t'(i), waits);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Output monitor: a handshake completes at the next rising edge.
   always @(negedge clk) begin
      if (rst && bif.out_valid && bif.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_depth", mat_t'(exp_q.size()), 1);
         end else begin
            chk("block", bif.out_matrix, exp_q.pop_front());
            chk("blocks_out_at_handoff", bif.blocks_out, exp_blocks);
            exp_blocks = exp_blocks + 32'd1;
         end
      end
   end

   initial begin
      int waits;
      int t;
      bif.in_word   = '0;
      bif.in_valid  = 1'b0;
      bif.abort     = 1'b0;
      bif.out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid",  bif.out_valid,  0);
      chk("rst_out_matrix", bif.out_matrix, 0);
      chk("rst_fill_level", bif.fill_level, 0);
      chk("rst_blocks_out", bif.blocks_out, 0);
      chk("rst_in_ready",   bif.in_ready,   1);
      rst = 1'b1;
      idle(1);

      // Single block, consumer always ready
      bif.out_ready = 1'b1;
      send_words(32'h0, 16);
      chk("t1_latency_out_valid", bif.out_valid, 1);
      chk("t1_m00", bif.out_matrix[0][0], 32'h0);
      chk("t1_m12", bif.out_matrix[1][2], 32'h6);
      chk("t1_m33", bif.out_matrix[3][3], 32'hF);
      idle(1);
      chk("t1_blocks_out", bif.blocks_out, 1);
      chk("t1_out_valid_clear", bif.out_valid, 0);

      // Both banks fill with consumer stalled, then drain
      bif.out_ready = 1'b0;
      send_words(32'h100, 32);
      chk("t2_in_ready_low", bif.in_ready, 0);
      chk("t2_hold0", bif.out_matrix, exp_q[0]);
      idle(3);
      chk("t2_hold1", bif.out_matrix, exp_q[0]);
      chk("t2_in_ready_still_low", bif.in_ready, 0);
      bif.out_ready = 1'b1;
      send_word(32'h120, waits);
      chk("t2_word32_wait", mat_t'(waits), 1);
      send_words(32'h121, 15);
      idle(3);
      chk("t2_drained", mat_t'(exp_q.size()), 0);
      chk("t2_blocks_out", bif.blocks_out, 4);

      // abort discards a partial block
      send_words(32'h200, 7);
      chk("t3_fill_level_7", bif.fill_level, 7);
      bif.abort = 1'b1;
      idle(1);
      bif.abort = 1'b0;
      model_drop_partial();
      chk("t3_fill_level_0", bif.fill_level, 0);
      chk("t3_no_out_valid", bif.out_valid, 0);
      send_words(32'hA0, 16);
      chk("t3_a0", bif.out_matrix[0][0], 32'hA0);
      idle(2);
      chk("t3_blocks_out", bif.blocks_out, 5);

      // abort coinciding with a word while the other bank is FULL
      bif.out_ready = 1'b0;
      send_words(32'hB0, 16);
      send_words(32'hC0, 3);
      chk("t4_fill_level_3", bif.fill_level, 3);
      bif.in_word  = 32'hDEAD_BEEF;
      bif.in_valid = 1'b1;
      bif.abort    = 1'b1;
      @(negedge clk);
      chk("t4_in_ready_ungated", bif.in_ready, 1);
      @(posedge clk); #1;
      bif.abort    = 1'b0;
      bif.in_valid = 1'b0;
      model_drop_partial();
      chk("t4_fill_level_0", bif.fill_level, 0);
      chk("t4_full_kept", bif.out_valid, 1);
      chk("t4_blocks_out_hold", bif.blocks_out, 5);
      bif.out_ready = 1'b1;
      idle(2);
      chk("t4_blocks_out_after", bif.blocks_out, 6);
      send_words(32'hD0, 16);
      idle(2);
      chk("t4_blocks_out_next", bif.blocks_out, 7);

      // Asynchronous reset mid-block
      send_words(32'h300, 9);
      chk("t5_fill_level_9", bif.fill_level, 9);
      rst = 1'b0;
      #1;
      model_reset();
      chk("t5_fill_level_rst", bif.fill_level, 0);
      chk("t5_blocks_out_rst", bif.blocks_out, 0);
      idle(1);
      rst = 1'b1;
      idle(1);

      // Asynchronous reset while a block is held
      bif.out_ready = 1'b0;
      send_words(32'h400, 16);
      chk("t5_hold_valid", bif.out_valid, 1);
      rst = 1'b0;
      #1;
      model_reset();
      chk("t5_valid_rst", bif.out_valid, 0);
      chk("t5_matrix_rst", bif.out_matrix, 0);
      chk("t5_in_ready_rst", bif.in_ready, 1);
      idle(1);
      rst = 1'b1;
      idle(1);
      bif.out_ready = 1'b1;
      send_words(32'h500, 16);
      idle(2);
      chk("t5_clean_block_count", bif.blocks_out, 1);

      // blocks_out wrap
      force dut.r_blocks_out = 32'hFFFF_FFFF;
      #1;
      release dut.r_blocks_out;
      exp_blocks = 32'hFFFF_FFFF;
      idle(1);
      chk("t6_preload", bif.blocks_out, 32'hFFFF_FFFF);
      send_words(32'h600, 16);
      idle(2);
      chk("t6_wrap", bif.blocks_out, 0);

      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         idle(1);
         t++;
      end
      chk("sb_final_empty", mat_t'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_block_deserialiser
